// File: rtl/if_stage_prefetch.sv
// rtl/if_stage_prefetch.sv - instruction fetch stage with DEPTH-entry prefetch queue
// Optional IF_PERF_CNT_EN adds delivered/flushed performance counters.
module if_stage_prefetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Branch_taken,
  input  logic [ADDR_W-1:0]  BranchAddr,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  PC,
  output logic [INSTR_W-1:0] Instruction
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_delivered,
  output logic [31:0]        perf_flushed
`endif
);

  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  pc_fetch_q, pc_fetch_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  fifo_pc_q    [DEPTH];
  logic [INSTR_W-1:0] fifo_instr_q [DEPTH];

  logic               pop, push, issue;
  logic [CNT_W:0]     occupancy;

  // Head is hidden during reset so a stale pre-reset entry can never be popped.
  assign out_valid   = ~rst & ~Branch_taken & (count_q != '0);
  assign pop         = out_valid & out_ready;
  assign push        = inflight_q & ~Branch_taken;
  assign occupancy   = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue       = ~rst & ~Branch_taken & (occupancy < (CNT_W+1)'(DEPTH));
  assign imem_en     = issue;
  assign imem_addr   = pc_fetch_q;
  assign PC          = fifo_pc_q[rd_ptr_q];
  assign Instruction = fifo_instr_q[rd_ptr_q];

  always_comb begin
    pc_fetch_d = issue ? pc_fetch_q + STEP : pc_fetch_q;
    req_pc_d   = issue ? pc_fetch_q : req_pc_q;
    inflight_d = issue;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    if (Branch_taken) begin
      pc_fetch_d = BranchAddr;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_fetch_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_fetch_q <= pc_fetch_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q + STEP;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_delivered_q, perf_delivered_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] flush_sum;

  always_comb begin
    flush_sum        = {1'b0, perf_flushed_q} + 33'(count_q) + 33'(inflight_q);
    perf_delivered_d = perf_delivered_q + 32'(pop);
    perf_flushed_d   = perf_flushed_q;
    if (Branch_taken) begin
      perf_flushed_d = flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_delivered_q <= '0;
      perf_flushed_q   <= '0;
    end else begin
      perf_delivered_q <= perf_delivered_d;
      perf_flushed_q   <= perf_flushed_d;
    end
  end

  assign perf_delivered = perf_delivered_q;
  assign perf_flushed   = perf_flushed_q;
`endif

endmodule

// File: tb/tb_if_stage_prefetch.sv
// tb/tb_if_stage_prefetch.sv - directed self-checking bench for if_stage_prefetch
// Instruction memory model returns addr ^ 32'hA5A5_0000 one cycle after imem_en.
module tb_if_stage_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        Branch_taken;
  logic [31:0] BranchAddr;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] PC;
  logic [31:0] Instruction;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_delivered;
  logic [31:0] perf_flushed;
`endif

  int n_vec = 0;
  int n_err = 0;

  if_stage_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .Branch_taken (Branch_taken),
    .BranchAddr   (BranchAddr),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .PC           (PC),
    .Instruction  (Instruction)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_delivered (perf_delivered),
    .perf_flushed   (perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; Branch_taken = 1'b0; BranchAddr = '0;

    // Reset release, streaming with out_ready high
    cyc(); cyc(); #1;
    chk("rst_en", 64'(imem_en), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    cyc(); rst = 1'b0; #1;
    chk("c0_en", 64'(imem_en), 64'd1);
    chk("c0_addr", 64'(imem_addr), 64'h0);
    chk("c0_valid", 64'(out_valid), 64'd0);
    cyc(); #1;
    chk("c1_addr", 64'(imem_addr), 64'h4);
    chk("c1_valid", 64'(out_valid), 64'd0);
    for (int k = 2; k <= 6; k++) begin
      cyc(); #1;
      chk("str_valid", 64'(out_valid), 64'd1);
      chk("str_pc", 64'(PC), 64'(32'(4 * (k - 1))));
      chk("str_instr", 64'(Instruction), 64'(32'(4 * (k - 2)) ^ 32'hA5A5_0000));
      chk("str_addr", 64'(imem_addr), 64'(32'(4 * k)));
    end

    // Backpressure from reset release
    cyc(); rst = 1'b1; out_ready = 1'b0; #1;
    cyc(); rst = 1'b0; #1;
    chk("bp_c0_addr", 64'(imem_addr), 64'h0);
    cyc(); #1;
    chk("bp_c1_addr", 64'(imem_addr), 64'h4);
    cyc(); #1;
    chk("bp_c2_addr", 64'(imem_addr), 64'h8);
    chk("bp_c2_pc", 64'(PC), 64'h4);
    cyc(); #1;
    chk("bp_c3_addr", 64'(imem_addr), 64'hC);
    chk("bp_c3_en", 64'(imem_en), 64'd1);
    cyc(); #1;
    chk("bp_c4_en", 64'(imem_en), 64'd0);
    cyc(); #1;
    chk("bp_c5_en", 64'(imem_en), 64'd0);
    chk("bp_c5_valid", 64'(out_valid), 64'd1);
    chk("bp_c5_pc", 64'(PC), 64'h4);
    cyc(); out_ready = 1'b1; #1;
    chk("bp_c6_pc", 64'(PC), 64'h4);
    chk("bp_c6_addr", 64'(imem_addr), 64'h10);
    chk("bp_c6_en", 64'(imem_en), 64'd1);
    cyc(); #1;
    chk("bp_c7_pc", 64'(PC), 64'h8);
    cyc(); #1;
    chk("bp_c8_pc", 64'(PC), 64'hC);
    cyc(); #1;
    chk("bp_c9_pc", 64'(PC), 64'h10);

    // Branch with 3 queued entries and 1 read in flight
    cyc(); rst = 1'b1; out_ready = 1'b0; #1;
    cyc(); rst = 1'b0; #1;
    repeat (3) cyc();
    cyc(); Branch_taken = 1'b1; BranchAddr = 32'h100; #1;
    chk("br_valid", 64'(out_valid), 64'd0);
    chk("br_en", 64'(imem_en), 64'd0);
    cyc(); Branch_taken = 1'b0; out_ready = 1'b1; #1;
    chk("br_n1_valid", 64'(out_valid), 64'd0);
    chk("br_n1_addr", 64'(imem_addr), 64'h100);
`ifdef IF_PERF_CNT_EN
    chk("perf_flushed", 64'(perf_flushed), 64'd4);
    chk("perf_delivered", 64'(perf_delivered), 64'd0);
`endif
    cyc(); #1;
    chk("br_n2_valid", 64'(out_valid), 64'd0);
    chk("br_n2_addr", 64'(imem_addr), 64'h104);
    cyc(); #1;
    chk("br_n3_valid", 64'(out_valid), 64'd1);
    chk("br_n3_pc", 64'(PC), 64'h104);
    chk("br_n3_instr", 64'(Instruction), 64'hA5A5_0100);

    // Back-to-back branches: last target wins
    cyc(); Branch_taken = 1'b1; BranchAddr = 32'h200; #1;
    chk("bb0_en", 64'(imem_en), 64'd0);
    chk("bb0_valid", 64'(out_valid), 64'd0);
    cyc(); BranchAddr = 32'h300; #1;
    chk("bb1_en", 64'(imem_en), 64'd0);
    cyc(); Branch_taken = 1'b0; #1;
    chk("bb2_addr", 64'(imem_addr), 64'h300);
    chk("bb2_valid", 64'(out_valid), 64'd0);
    cyc(); #1;
    chk("bb3_addr", 64'(imem_addr), 64'h304);
    chk("bb3_valid", 64'(out_valid), 64'd0);
    cyc(); #1;
    chk("bb4_valid", 64'(out_valid), 64'd1);
    chk("bb4_pc", 64'(PC), 64'h304);
    chk("bb4_instr", 64'(Instruction), 64'hA5A5_0300);

    // Fetch address wrap at top of address space
    cyc(); Branch_taken = 1'b1; BranchAddr = 32'hFFFF_FFFC; #1;
    cyc(); Branch_taken = 1'b0; #1;
    chk("wr_addr0", 64'(imem_addr), 64'hFFFF_FFFC);
    cyc(); #1;
    chk("wr_addr1", 64'(imem_addr), 64'h0);
    cyc(); #1;
    chk("wr_valid", 64'(out_valid), 64'd1);
    chk("wr_pc", 64'(PC), 64'h0);
    chk("wr_instr", 64'(Instruction), 64'h5A5A_FFFC);
    cyc(); #1;
    chk("wr_pc2", 64'(PC), 64'h4);
    chk("wr_instr2", 64'(Instruction), 64'hA5A5_0000);

    // Reset mid-stream with queued entries and a read in flight
    cyc(); Branch_taken = 1'b1; BranchAddr = 32'h800; out_ready = 1'b0; #1;
    cyc(); Branch_taken = 1'b0; #1;
    repeat (3) cyc();
    cyc(); rst = 1'b1; #1;
    chk("mr_rst_en", 64'(imem_en), 64'd0);
    cyc(); rst = 1'b0; out_ready = 1'b1; #1;
    chk("mr_n1_valid", 64'(out_valid), 64'd0);
    chk("mr_n1_addr", 64'(imem_addr), 64'h0);
    chk("mr_n1_en", 64'(imem_en), 64'd1);
    cyc(); #1;
    chk("mr_n2_valid", 64'(out_valid), 64'd0);
    chk("mr_n2_addr", 64'(imem_addr), 64'h4);
    cyc(); #1;
    chk("mr_n3_valid", 64'(out_valid), 64'd1);
    chk("mr_n3_pc", 64'(PC), 64'h4);
    chk("mr_n3_instr", 64'(Instruction), 64'hA5A5_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage_prefetch.md
Name: if_stage_prefetch

Overview:
Parametrised instruction-fetch stage with a prefetch queue, decoupling instruction-memory reads from the decode stage. It issues sequential fetches to a synchronous instruction memory (1-cycle read latency) and buffers the returned instruction with its next-PC in a DEPTH-entry FIFO. It delivers them to ID over a valid/ready handshake. A taken branch flushes the queue, discards the in-flight read and redirects fetch.

Parameters:
ADDR_W, 32, PC / address width
INSTR_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, minimum 2)
RESET_PC, 0, fetch address after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
Branch_taken  input  1  redirect request from EXE, priority over all other activity
BranchAddr  input  ADDR_W  redirect target
imem_en  output  1  read request this cycle
imem_addr  output  ADDR_W  read address
imem_rdata  input  INSTR_W  read data, valid the cycle after imem_en
out_valid  output  1  FIFO head presented to ID
out_ready  input  1  ID accepts head (replaces freeze: freeze == ~out_ready)
PC  output  ADDR_W  head entry's fetch address + PC_STEP
Instruction  output  INSTR_W  head entry's instruction

Behaviour:
- Reset: synchronous, active-high; sampled on rising edge of clk. Forces pc_fetch=RESET_PC, FIFO count=0, rd/wr pointers=0, inflight=0. Outputs in the cycle after reset: out_valid=0, imem_en=0 only if reset still high, else a fetch of RESET_PC is issued. PC/Instruction are don't-care while out_valid=0 but driven from FIFO head (no X propagation required).
- pop = out_valid & out_ready.
- Issue rule (combinational): imem_en = ~rst & ~Branch_taken & (count + inflight - pop < DEPTH). imem_addr = pc_fetch. On issue: pc_fetch <= pc_fetch + PC_STEP (mod 2^ADDR_W, wraps silently); inflight <= 1; req_pc <= pc_fetch. Without issue, inflight <= 0.
- Response: if inflight=1 and no Branch_taken this cycle, push {req_pc+PC_STEP, imem_rdata} at the cycle's closing edge.
- Output: out_valid = (count != 0) & ~Branch_taken; PC/Instruction = head entry.
- Simultaneous push and pop: count unchanged, both pointers advance. Push never occurs when full (guaranteed by issue rule; verification asserts it).
- Latency: request in cycle N -> entry visible (out_valid=1) in cycle N+2. Sustains 1 instruction/cycle with out_ready held high for DEPTH>=2.
- Branch_taken cycle: no issue, no pop, in-flight response dropped. FIFO emptied at the edge (count=0, pointers reset). pc_fetch <= BranchAddr. Target fetched in the next cycle, delivered 2 cycles after that. Branch_taken on consecutive cycles: last target wins.
- Branch_taken and rst together: rst wins.
- Backpressure: out_ready=0 holds head stable (PC/Instruction unchanged); fetching continues until count+inflight == DEPTH, then imem_en=0.
- BranchAddr used unmodified (no alignment forcing).

Optional Feature:
IF_PERF_CNT_EN. When defined, adds outputs perf_delivered (32-bit, +1 per pop) and perf_flushed (32-bit, +count+inflight dropped at each Branch_taken, saturating at 2^32-1). Both are cleared by rst. When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, out_ready=1, imem returns mem[a]=a ^ 0xA5A5_0000: imem_addr 0,4,8… on consecutive cycles; first out_valid 2 cycles after rst low with PC=4, Instruction=0xA5A5_0000; then one instruction per cycle.
- Hold out_ready=0 from start, DEPTH=4: exactly 4 fetches (0,4,8,12), imem_en then 0, count=4; PC=4 stable; release out_ready -> PCs 4,8,12,16 on consecutive cycles, fetch resumes at 16.
- Branch_taken=1, BranchAddr=0x100 with 3 entries queued and 1 in flight: out_valid=0 that cycle, queue empty after. Next imem_addr=0x100; next delivered PC=0x104; no stale PC delivered (perf_flushed +=4 when IF_PERF_CNT_EN).
- Branch_taken in consecutive cycles, targets 0x200 then 0x300: only 0x300 fetched; first delivered PC=0x304.
- pc_fetch=0xFFFF_FFFC sequential fetch: next imem_addr=0x0000_0000; delivered PC for that entry=0x0000_0000.
- rst asserted mid-stream with full FIFO and inflight: next cycle out_valid=0, imem_addr=RESET_PC after rst drops, no pre-reset instruction ever delivered.
